// File: rtl/dice_roll_engine.sv
// dice_roll_engine
// Rolls NUM_DICE dice. Each die that is not held gets a value in 1..FACES.
// Each turn allows up to MAX_ROLLS rolls.
// The random source is a 32-bit Fibonacci LFSR (taps 32,22,2,1) that shifts
// on every cycle. The first accepted roll after reset mixes a free-running
// cycle counter into the LFSR, so results depend on when the player presses.
// Dice are resolved one per cycle. A candidate that falls outside 1..FACES
// is retried. On the eighth attempt for the same die, the candidate is folded
// with a modulo instead, which bounds the roll latency.
// Optional build macro: DICE_ANIM_EN. When it is defined, unresolved dice
// show a changing random face while the roll is in progress.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for roll_req / new_turn
// S_ROLL | resolving one die index per cycle, retrying out-of-range draws
// S_DONE | one-cycle completion pulse on done

module dice_roll_engine #(
  parameter int          NUM_DICE  = 5,
  parameter int          FACES     = 6,
  parameter int          MAX_ROLLS = 3,
  parameter logic [31:0] SEED      = 32'hACE1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  roll_req,
  input  logic                  new_turn,
  input  logic [NUM_DICE-1:0]   hold_mask,
  output logic [3*NUM_DICE-1:0] dice_flat,
  output logic                  busy,
  output logic                  done,
  output logic                  roll_reject,
  output logic [2:0]            rolls_left
);

  localparam logic [2:0]          LP_FACES     = 3'(FACES);
  localparam logic [2:0]          LP_MAX_ROLLS = 3'(MAX_ROLLS);
  localparam logic [2:0]          LP_LAST_IDX  = 3'(NUM_DICE - 1);
  localparam logic [2:0]          LP_MAX_RETRY = 3'd7;
  localparam logic [NUM_DICE-1:0] LP_ALL_HELD  = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ROLL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [31:0]           r_lfsr;
  logic [31:0]           r_cnt;
  logic                  r_seeded;
  logic [2:0]            r_idx;
  logic [2:0]            r_retry;
  logic [NUM_DICE-1:0]   r_hold;
  logic [2:0]            r_rolls_left;
  logic                  r_reject;
  logic [2:0]            r_dice [NUM_DICE];

  logic                  w_lfsr_fb;
  logic [31:0]           w_lfsr_shift;
  logic [31:0]           w_lfsr_mix;
  logic [2:0]            w_cand;
  logic                  w_cand_ok;
  logic [2:0]            w_cand_mod;
  logic [2:0]            w_die_val;
  logic                  w_held;
  logic                  w_accept;
  logic                  w_reject;
  logic                  w_reload;
  logic                  w_advance;

  assign w_lfsr_fb    = r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0];
  assign w_lfsr_shift = {r_lfsr[30:0], w_lfsr_fb};
  assign w_lfsr_mix   = r_lfsr ^ r_cnt;

  assign w_cand     = r_lfsr[2:0];
  assign w_cand_ok  = (w_cand < LP_FACES);
  assign w_cand_mod = 3'({29'd0, w_cand} % 32'(FACES));
  assign w_die_val  = (w_cand_ok ? w_cand : w_cand_mod) + 3'd1;
  assign w_held     = r_hold[r_idx];

`ifdef DICE_ANIM_EN
  logic [2:0] w_anim;
  assign w_anim = 3'({29'd0, r_lfsr[5:3]} % 32'(FACES)) + 3'd1;
`endif

  // Random source: LFSR with a one-time entropy mix on the first accepted roll.
  // An all-zero state would lock the LFSR, so SEED is loaded in its place.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr   <= SEED;
      r_cnt    <= 32'd0;
      r_seeded <= 1'b0;
    end else begin
      r_cnt <= r_cnt + 32'd1;
      if (w_accept && !r_seeded) begin
        r_seeded <= 1'b1;
        r_lfsr   <= (w_lfsr_mix == 32'd0) ? SEED : w_lfsr_mix;
      end else if (r_lfsr == 32'd0) begin
        r_lfsr <= SEED;
      end else begin
        r_lfsr <= w_lfsr_shift;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and request arbitration. new_turn wins over roll_req in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_reload    = 1'b0;
    w_advance   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (new_turn) begin
          w_reload = 1'b1;
          w_reject = roll_req;
        end else if (roll_req) begin
          if ((r_rolls_left != 3'd0) && (hold_mask != LP_ALL_HELD)) begin
            w_accept    = 1'b1;
            w_state_nxt = S_ROLL;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      S_ROLL: begin
        w_reject = roll_req;
        if (w_held || w_cand_ok || (r_retry == LP_MAX_RETRY)) begin
          w_advance = 1'b1;
          if (r_idx == LP_LAST_IDX) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_reject    = roll_req;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Roll bookkeeping: latched hold mask, die index, retry count, turn budget.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx        <= 3'd0;
      r_retry      <= 3'd0;
      r_hold       <= '0;
      r_rolls_left <= LP_MAX_ROLLS;
      r_reject     <= 1'b0;
    end else begin
      r_reject <= w_reject;
      if (w_reload) begin
        r_rolls_left <= LP_MAX_ROLLS;
      end else if (w_accept) begin
        r_rolls_left <= r_rolls_left - 3'd1;
      end
      if (w_accept) begin
        r_hold  <= hold_mask;
        r_idx   <= 3'd0;
        r_retry <= 3'd0;
      end else if (r_state == S_ROLL) begin
        if (w_advance) begin
          r_idx   <= r_idx + 3'd1;
          r_retry <= 3'd0;
        end else begin
          r_retry <= r_retry + 3'd1;
        end
      end
    end
  end

  // Die value registers. Only the current index can resolve. In the animated
  // build, the current die and the dice after it that are not held show a
  // changing random face until they resolve.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_DICE; i++) begin
        r_dice[i] <= 3'd1;
      end
    end else if (r_state == S_ROLL) begin
      for (int i = 0; i < NUM_DICE; i++) begin
        if (3'(i) == r_idx) begin
          if (w_advance && !w_held) begin
            r_dice[i] <= w_die_val;
          end
`ifdef DICE_ANIM_EN
          else if (!w_held) begin
            r_dice[i] <= w_anim;
          end
        end else if ((3'(i) > r_idx) && !r_hold[i]) begin
          r_dice[i] <= w_anim;
`endif
        end
      end
    end
  end

  // Output packing.
  for (genvar g = 0; g < NUM_DICE; g++) begin : g_flat
    assign dice_flat[3*g +: 3] = r_dice[g];
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign roll_reject = r_reject;
  assign rolls_left  = r_rolls_left;

endmodule

// File: tb/tb_dice_roll_engine.sv
// Scoreboard bench for dice_roll_engine.
// Stimulus pushes the expected responses into queues. A monitor that samples
// on the falling edge pops and compares an entry each time done or
// roll_reject is seen. The model tracks the turn budget and the dice values
// accepted so far. Held dice must keep those values. Rolled dice must land
// in 1..FACES within the allowed latency window.

module tb_dice_roll_engine;

  localparam int ND = 5;
  localparam int NF = 6;
  localparam int MR = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          roll_req = 1'b0;
  logic          new_turn = 1'b0;
  logic [ND-1:0] hold_mask = '0;
  logic [3*ND-1:0] dice_flat;
  logic          busy;
  logic          done;
  logic          roll_reject;
  logic [2:0]    rolls_left;

  dice_roll_engine #(.NUM_DICE(ND), .FACES(NF), .MAX_ROLLS(MR), .SEED(32'hACE1)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .roll_req    (roll_req),
    .new_turn    (new_turn),
    .hold_mask   (hold_mask),
    .dice_flat   (dice_flat),
    .busy        (busy),
    .done        (done),
    .roll_reject (roll_reject),
    .rolls_left  (rolls_left)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]      rl;
    logic [ND-1:0]   hold;
    logic [3*ND-1:0] prior;
    int              acc;
  } done_exp_t;

  typedef struct {
    logic [2:0]      rl;
    bit              chk_dice;
    logic [3*ND-1:0] dice;
  } rej_exp_t;

  done_exp_t dq[$];
  rej_exp_t  rq[$];

  int              n_chk = 0;
  int              n_pass = 0;
  int              m_rl;
  logic [3*ND-1:0] m_dice;
  bit              count_en = 1'b0;
  int              hist[8];

  function automatic void chk(string nm, longint act, longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endfunction

  function automatic void chk_range(string nm, longint act, longint lo, longint hi);
    n_chk++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d expected %0d..%0d (t=%0t)", nm, act, lo, hi, $time);
  endfunction

  function automatic logic [3*ND-1:0] all_ones();
    logic [3*ND-1:0] v;
    for (int i = 0; i < ND; i++) v[3*i +: 3] = 3'd1;
    return v;
  endfunction

  // Monitor: compare each completion / rejection against the scoreboard.
  done_exp_t de;
  rej_exp_t  re;
  always @(negedge clk) begin
    if (reset_n) begin
      if (done) begin
        if (dq.size() == 0) begin
          chk("done_without_request", dq.size(), 1);
        end else begin
          de = dq.pop_front();
          chk("done_rolls_left", rolls_left, de.rl);
          chk("done_busy", busy, 1);
          chk_range("roll_latency", cyc - de.acc, ND, 8 * ND);
          for (int i = 0; i < ND; i++) begin
            if (de.hold[i]) begin
              chk($sformatf("held_die%0d", i), dice_flat[3*i +: 3], de.prior[3*i +: 3]);
            end else begin
              chk_range($sformatf("die%0d_value", i), dice_flat[3*i +: 3], 1, NF);
              if (count_en) hist[dice_flat[3*i +: 3]]++;
            end
          end
          m_dice = dice_flat;
        end
      end
      if (roll_reject) begin
        if (rq.size() == 0) begin
          chk("reject_without_cause", rq.size(), 1);
        end else begin
          re = rq.pop_front();
          chk("reject_rolls_left", rolls_left, re.rl);
          if (re.chk_dice) chk("reject_dice_kept", dice_flat, re.dice);
        end
      end
    end
  end

  task automatic push_done(input logic [ND-1:0] mask);
    done_exp_t e;
    m_rl--;
    e.rl = 3'(m_rl); e.hold = mask; e.prior = m_dice; e.acc = cyc + 1;
    dq.push_back(e);
  endtask

  task automatic push_rej(input bit cd);
    rej_exp_t e;
    e.rl = 3'(m_rl); e.chk_dice = cd; e.dice = m_dice;
    rq.push_back(e);
  endtask

  task automatic drain(input bit toggle);
    for (int i = 0; i < 120 && (dq.size() != 0 || rq.size() != 0); i++) begin
      @(posedge clk);
      #1;
      if (toggle) hold_mask = 5'($urandom);
    end
    if (dq.size() != 0 || rq.size() != 0) begin
      chk("response_timeout", dq.size() + rq.size(), 0);
      dq.delete();
      rq.delete();
    end
  endtask

  // One IDLE request; the model decides accept vs reject from the rules.
  task automatic req(input logic [ND-1:0] mask, input bit nt, input bit toggle);
    @(posedge clk);
    #1;
    hold_mask = mask;
    roll_req  = 1'b1;
    new_turn  = nt;
    if (nt) begin
      m_rl = MR;
      push_rej(1'b1);
    end else if (m_rl > 0 && mask != '1) begin
      push_done(mask);
    end else begin
      push_rej(1'b1);
    end
    @(posedge clk);
    #1;
    roll_req = 1'b0;
    new_turn = 1'b0;
    drain(toggle);
  endtask

  task automatic do_new_turn();
    @(posedge clk);
    #1;
    new_turn = 1'b1;
    m_rl = MR;
    @(posedge clk);
    #1;
    new_turn = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    m_rl = MR;
    m_dice = all_ones();
    for (int f = 0; f < 8; f++) hist[f] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_dice", dice_flat, all_ones());
    chk("reset_rolls_left", rolls_left, MR);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_reject", roll_reject, 0);

    // Three accepted rolls, then a refused fourth with dice kept.
    for (int k = 0; k < 4; k++) req('0, 1'b0, 1'b0);
    chk("budget_exhausted", rolls_left, 0);

    do_new_turn();
    chk("new_turn_reload", rolls_left, MR);
    chk("new_turn_dice_kept", dice_flat, m_dice);

    // Held dice 0,2,4 with the mask wiggling during the roll.
    req(5'b10101, 1'b0, 1'b1);

    // All dice held: refused, no roll starts.
    req(5'b11111, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("all_held_busy", busy, 0);
    end
    chk("all_held_rolls_left", rolls_left, m_rl);

    // Exhaust, then new_turn together with roll_req.
    while (m_rl > 0) req('0, 1'b0, 1'b0);
    req('0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("nt_and_roll_busy", busy, 0);
    chk("nt_and_roll_rolls_left", rolls_left, MR);

    // roll_req and new_turn while busy: reject, new_turn ignored.
    @(posedge clk);
    #1;
    hold_mask = '0;
    roll_req = 1'b1;
    push_done('0);
    @(posedge clk);
    #1;
    roll_req = 1'b0;
    @(posedge clk);
    #1;
    roll_req = 1'b1;
    new_turn = 1'b1;
    push_rej(1'b0);
    @(posedge clk);
    #1;
    roll_req = 1'b0;
    new_turn = 1'b0;
    drain(1'b0);
    @(posedge clk);
    #1;
    chk("busy_new_turn_ignored", rolls_left, m_rl);

    // Randomized mix of masks and turn resets.
    for (int k = 0; k < 80; k++) begin
      logic [ND-1:0] mk;
      mk = ($urandom_range(0, 9) == 0) ? '1 : 5'($urandom);
      req(mk, ($urandom_range(0, 4) == 0), 1'($urandom));
    end

    // Reset in the middle of a roll.
    do_new_turn();
    @(posedge clk);
    #1;
    hold_mask = '0;
    roll_req = 1'b1;
    @(posedge clk);
    #1;
    roll_req = 1'b0;
    @(posedge clk);
    #1;
    chk("midroll_busy_before", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("midroll_reset_dice", dice_flat, all_ones());
    chk("midroll_reset_busy", busy, 0);
    chk("midroll_reset_done", done, 0);
    chk("midroll_reset_rolls_left", rolls_left, MR);
    dq.delete();
    rq.delete();
    m_rl = MR;
    m_dice = all_ones();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    chk("after_reset_busy", busy, 0);

    // Face distribution over 10000 die values.
    count_en = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      if (m_rl == 0) do_new_turn();
      req('0, 1'b0, 1'b0);
    end
    count_en = 1'b0;
    for (int f = 1; f <= NF; f++) begin
      chk_range($sformatf("face%0d_count", f), hist[f], 1500, 1834);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dice_roll_engine.md
DICE_ROLL_ENGINE -- requirements
Module: dice_roll_engine

Interface
REQ-001 SHALL have parameter NUM_DICE, default 5, number of dice, range 1..8.
REQ-002 SHALL have parameter FACES, default 6, faces per die, range 2..7.
REQ-003 SHALL have parameter MAX_ROLLS, default 3, rolls allowed per turn, range 1..7.
REQ-004 SHALL have parameter SEED, default 32'hACE1, non-zero LFSR base seed.
REQ-005 clk  input  1  system clock, all logic on rising edge.
REQ-006 reset_n  input  1  reset, asynchronous and active-low.
REQ-007 roll_req  input  1  single-cycle request to roll non-held dice.
REQ-008 new_turn  input  1  single-cycle request to start a new turn.
REQ-009 hold_mask  input  NUM_DICE  bit i=1 holds die i.
REQ-010 dice_flat  output  3*NUM_DICE  die i value in bits [3i+2:3i], range 1..FACES.
REQ-011 busy  output  1  high while a roll is in progress.
REQ-012 done  output  1  single-cycle pulse when a roll completes.
REQ-013 roll_reject  output  1  single-cycle pulse when a request is refused.
REQ-014 rolls_left  output  3  rolls remaining in the current turn.

Function
REQ-015 SHALL run a 32-bit Fibonacci LFSR with taps 32,22,2,1 that shifts every cycle out of reset.
REQ-016 SHALL run a 32-bit entropy counter that increments every cycle out of reset.
REQ-017 On the first accepted roll_req after reset, the LFSR SHALL load lfsr^counter; any all-zero LFSR state SHALL instead load SEED.
REQ-018 SHALL implement FSM IDLE->ROLL->DONE->IDLE; DONE lasts exactly one cycle and asserts done.
REQ-019 roll_req in IDLE SHALL be accepted only if rolls_left>0 and hold_mask is not all ones; otherwise roll_reject pulses the following cycle and state is unchanged.
REQ-020 On accept: register hold_mask, decrement rolls_left, set die index to 0, enter ROLL next cycle; busy=1 from that cycle through DONE inclusive.
REQ-021 ROLL, one die index per cycle:
  - held die: advance index, value unchanged;
  - candidate v=lfsr[2:0] with v<FACES: die=v+1, advance;
  - otherwise reject and retry next cycle.
REQ-022 After 7 consecutive rejects on one die, the 8th attempt SHALL use (v mod FACES)+1, bounding latency to at most 8*NUM_DICE ROLL cycles; minimum latency is NUM_DICE cycles.
REQ-023 Leaving ROLL after the last index SHALL enter DONE.
REQ-024 hold_mask changes during ROLL SHALL be ignored.
REQ-025 roll_req while busy SHALL pulse roll_reject; new_turn while busy SHALL be ignored.
REQ-026 new_turn in IDLE SHALL reload rolls_left=MAX_ROLLS next cycle; dice values are kept.
REQ-027 Simultaneous new_turn and roll_req in IDLE: new_turn SHALL take effect and roll_req SHALL be rejected (roll_reject pulses).
REQ-028 rolls_left SHALL never go below 0 and never exceed MAX_ROLLS.

Reset
REQ-029 reset_n low SHALL asynchronously force:
  - state IDLE, all dice=1;
  - rolls_left=MAX_ROLLS;
  - busy=0, done=0, roll_reject=0;
  - LFSR=SEED, counter=0, first-roll seeding flag cleared.
REQ-030 Reset mid-ROLL SHALL abort the roll with no done pulse.
REQ-031 After release, the first active edge SHALL operate normally.

Configuration
REQ-032 Macro DICE_ANIM_EN defined: during ROLL, every non-held die not yet resolved SHALL show (lfsr[5:3] mod FACES)+1, updated each cycle.
REQ-033 Macro DICE_ANIM_EN undefined: unresolved dice SHALL hold their previous value until resolved.
REQ-034 Final values, done timing and latency SHALL be identical in both configurations.

Verification
REQ-035 Reset, then check outputs: all dice=1, rolls_left=3, busy=0, done=0.
REQ-036 hold_mask=5'b00000, roll_req x3 then a 4th roll_req: three done pulses with each die in 1..6 and rolls_left 2,1,0; the 4th yields roll_reject, dice unchanged.
REQ-037 hold_mask=5'b10101, roll: dice 0, 2 and 4 unchanged; hold_mask toggled mid-roll has no effect.
REQ-038 hold_mask=5'b11111, roll_req: roll_reject=1, rolls_left unchanged, busy stays 0.
REQ-039 roll_req and new_turn in the same IDLE cycle with rolls_left=0: rolls_left=3, roll_reject=1, no roll.
REQ-040 Assert reset_n low during ROLL: immediate dice=1, busy=0, no done; 10000 rolls give every face value 1..6, with no face count outside ±10% of 1667.
